alu_mul_seq: RTL
================

# alu_mul_seq

Sequencer that computes an unsigned N×N→N multiply by driving the shared 16-bit `alu` datapath through shift-and-add steps (suma, shift_i, shift_d). It sits between the control unit and the `alu` instance. It owns the `alu` operand and opcode buses while busy, and returns the low N bits of the product plus a sticky overflow flag.

## Interface
- `N`, 16, operand/result width; must equal the `alu` instance's N (the `alu` carry output is taken from bit 16).
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  synchronous reset, active low.
- `i_start`  in  1  request; accepted only in IDLE.
- `i_op_a`  in  N  multiplicand, sampled on the accepting edge.
- `i_op_b`  in  N  multiplier, sampled on the accepting edge.
- `o_busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `o_done`  out  1  one-cycle pulse; result valid.
- `o_result`  out  N  low N bits of a×b; held until the next acceptance.
- `o_overflow`  out  1  true product ≥ 2^N; held with `o_result`.
- `o_alu_a`  out  N  to `alu` `i_a`.
- `o_alu_b`  out  N  to `alu` `i_b`.
- `o_alu_ctrl`  out  2  to `alu` `i_control`.
- `i_alu_q`  in  N  from `alu` `q`.
- `i_alu_mayor`  in  1  from `alu` `mayor` (carry of suma).

## Operation
- Internal registers: M (multiplicand), Q (multiplier), P (accumulator), cnt (log2 N bits), ovf.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - On `i_start` load M=a, Q=b, P=0, cnt=0, ovf=0.
  - Go to ADD if b[0], else SHL.
- ADD:
  - Drive a=P, b=M, ctrl=00.
  - P←`i_alu_q`; ovf←ovf|`i_alu_mayor`.
  - Go to SHL.
- SHL:
  - Drive a=M, b=0, ctrl=11.
  - M←`i_alu_q`; ovf←ovf|(M[N-1] & (Q[N-1:1]≠0)).
  - Go to SHR.
- SHR:
  - Drive a=Q, b=0, ctrl=01.
  - Q←`i_alu_q`; cnt←cnt+1.
  - If cnt==N-1, go to DONE; else go to ADD if `i_alu_q`[0], else SHL.
- DONE:
  - `o_done`=1; `o_result`←P and `o_overflow`←ovf (both registered on entry, so valid in DONE).
  - Go to IDLE.
- IDLE and DONE drive a=0, b=0, ctrl=00.
- `i_start` is ignored outside IDLE; no queuing.
- Arithmetic is modulo 2^N; the carry out of the `alu` is used only for ovf.
- Reset (any state): state=IDLE; M, Q, P, cnt, ovf = 0; all outputs 0.
  - Reset mid-operation aborts the multiply; no `o_done` is produced.

## Timing
- The `alu` is combinational; each ALU state samples `i_alu_q` at the end of the same cycle.
- Full-length latency (macro off): acceptance edge → DONE after 2N + popcount(b) cycles in ADD/SHL/SHR. `o_done` is high in the next cycle.
- `o_busy` is high exactly during ADD/SHL/SHR/DONE.
- Back-to-back: `i_start` is accepted earliest in the IDLE cycle following DONE.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN`
  - Defined:
    - SHR goes to DONE as soon as the new Q==0.
    - IDLE with b==0 goes straight to DONE with result 0, ovf 0.
    - Latency is data dependent.
  - Undefined: always N iterations; latency is fixed for a given popcount(b).
  - Results and ovf are identical either way.

## Structure
- Shared package `alu_pkg`:
  - ALU opcodes SUMA=2'b00, RESTA=2'b10, SHIFT_D=2'b01, SHIFT_I=2'b11 (also used by `alu`).
  - State encoding for this FSM.
- No sub-module: FSM, counter and registers are inline. The `alu` is instantiated by the parent, not inside this block.

## Test plan
- a=3, b=5, macro off → `o_done` after 34 busy cycles; result 15; ovf 0.
- a=3, b=5, macro on → DONE after 8 ALU cycles (ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR); result 15.
- a=0x0100, b=0x0100 → result 0x0000, ovf 1. Also a=0xFFFF, b=1 → result 0xFFFF, ovf 0.
- a=0x1234, b=0, macro on → DONE in the cycle after acceptance; result 0, ovf 0.
- `i_start` pulsed while busy, with different operands → ignored; the first result is unchanged.
- `i_rst_n` low for one cycle mid-SHL → all outputs 0 next cycle; no `o_done`; a new start then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes for the 16-bit alu datapath and the state encoding of the
// shift-and-add multiply sequencer that drives it.
package alu_pkg;

    typedef enum logic [1:0] {
        SUMA    = 2'b00,
        SHIFT_D = 2'b01,
        RESTA   = 2'b10,
        SHIFT_I = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bus between the control unit, the multiply sequencer and the shared alu.
// master = control unit / alu side, slave = sequencer.
interface alu_mul_seq_if #(parameter int N = 16);
    logic         i_start;
    logic [N-1:0] i_op_a;
    logic [N-1:0] i_op_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_result;
    logic         o_overflow;
    logic [N-1:0] o_alu_a;
    logic [N-1:0] o_alu_b;
    logic [1:0]   o_alu_ctrl;
    logic [N-1:0] i_alu_q;
    logic         i_alu_mayor;

    modport master (
        output i_start, i_op_a, i_op_b, i_alu_q, i_alu_mayor,
        input  o_busy, o_done, o_result, o_overflow, o_alu_a, o_alu_b, o_alu_ctrl
    );

    modport slave (
        input  i_start, i_op_a, i_op_b, i_alu_q, i_alu_mayor,
        output o_busy, o_done, o_result, o_overflow, o_alu_a, o_alu_b, o_alu_ctrl
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned NxN->N shift-and-add multiply using the external alu for every step.
// ALU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
//
// state   | meaning
// IDLE    | waiting for i_start, alu buses parked at zero
// ADD     | P <= P + M, carry folded into ovf
// SHL     | M <= M << 1, lost top bit counts as overflow if more adds remain
// SHR     | Q <= Q >> 1, iteration count advances
// DONE    | result/ovf registered, one-cycle o_done
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input logic i_clk,
    input logic i_rst_n,
    alu_mul_seq_if.slave bus
);

    localparam int CW = $clog2(N);

    mul_state_e    state, state_nx;
    logic [N-1:0]  m_reg, q_reg, p_reg;
    logic [N-1:0]  m_nx, q_nx, p_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ovf, ovf_nx;
    logic [N-1:0]  result_reg;
    logic          overflow_reg;
    logic [N-1:0]  alu_a, alu_b;
    alu_op_e       alu_ctrl;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            m_reg <= '0;
            q_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            m_reg <= m_nx;
            q_reg <= q_nx;
            p_reg <= p_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_nx     = m_reg;
        q_nx     = q_reg;
        p_nx     = p_reg;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = SUMA;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    m_nx   = bus.i_op_a;
                    q_nx   = bus.i_op_b;
                    p_nx   = '0;
                    cnt_nx = '0;
                    ovf_nx = 1'b0;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    if (bus.i_op_b == '0)
                        state_nx = ST_DONE;
                    else
`endif
                    state_nx = bus.i_op_b[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_ADD: begin
                alu_a    = p_reg;
                alu_b    = m_reg;
                alu_ctrl = SUMA;
                p_nx     = bus.i_alu_q;
                ovf_nx   = ovf | bus.i_alu_mayor;
                state_nx = ST_SHL;
            end
            ST_SHL: begin
                alu_a    = m_reg;
                alu_ctrl = SHIFT_I;
                m_nx     = bus.i_alu_q;
                // a dropped MSB only matters if a later add will use the shifted M
                ovf_nx   = ovf | (m_reg[N-1] & (|q_reg[N-1:1]));
                state_nx = ST_SHR;
            end
            ST_SHR: begin
                alu_a    = q_reg;
                alu_ctrl = SHIFT_D;
                q_nx     = bus.i_alu_q;
                cnt_nx   = cnt + CW'(1);
                if (cnt == CW'(N - 1))
                    state_nx = ST_DONE;
`ifdef ALU_MUL_EARLY_EXIT_EN
                else if (bus.i_alu_q == '0)
                    state_nx = ST_DONE;
`endif
                else
                    state_nx = bus.i_alu_q[0] ? ST_ADD : ST_SHL;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // capture on DONE entry so the values are already valid while o_done is high
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (state != ST_DONE && state_nx == ST_DONE) begin
            result_reg   <= p_nx;
            overflow_reg <= ovf_nx;
        end
    end

    assign bus.o_busy     = (state != ST_IDLE);
    assign bus.o_done     = (state == ST_DONE);
    assign bus.o_result   = result_reg;
    assign bus.o_overflow = overflow_reg;
    assign bus.o_alu_a    = alu_a;
    assign bus.o_alu_b    = alu_b;
    assign bus.o_alu_ctrl = alu_ctrl;

endmodule
